// File: rtl/vpu_ovi_issue_queue_if.sv
// Bundle of OVI issue, dispatch and backend signals for vpu_ovi_issue_queue.
// master = core/backend side, slave = the issue queue.
interface vpu_ovi_issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int SB_W   = 5,
    parameter int OPND_W = 64,
    parameter int VCSR_W = 41
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Issue port: no ready; the core may only issue while it holds credits.
    logic [31:0]       issue_inst;
    logic [SB_W-1:0]   issue_sb_id;
    logic [OPND_W-1:0] issue_scalar_opnd;
    logic [VCSR_W-1:0] issue_vcsr;
    logic              issue_valid;
    logic              issue_credit;

    logic [SB_W-1:0]   dispatch_sb_id;
    logic              dispatch_next_senior;
    logic              dispatch_kill;

    // Backend port: a beat transfers on a cycle where be_valid && be_ready.
    // Once be_valid rises it stays high, with be_* frozen, until that transfer.
    logic              be_valid;
    logic              be_ready;
    logic [31:0]       be_inst;
    logic [SB_W-1:0]   be_sb_id;
    logic [OPND_W-1:0] be_scalar_opnd;
    logic [VCSR_W-1:0] be_vcsr;

    logic [OCC_W-1:0]  occupancy;
    logic              proto_err;

    modport master (
        output issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_valid,
        input  issue_credit,
        output dispatch_sb_id, dispatch_next_senior, dispatch_kill,
        input  be_valid, be_inst, be_sb_id, be_scalar_opnd, be_vcsr,
        output be_ready,
        input  occupancy, proto_err
    );

    modport slave (
        input  issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_valid,
        output issue_credit,
        input  dispatch_sb_id, dispatch_next_senior, dispatch_kill,
        output be_valid, be_inst, be_sb_id, be_scalar_opnd, be_vcsr,
        input  be_ready,
        output occupancy, proto_err
    );
endinterface

// File: rtl/vpu_ovi_issue_queue.sv
// OVI issue-side circular queue: speculative issue, in-order senior/kill resolution, backend release.
// Optional protocol checking (sticky proto_err, dispatch id compare) is built when VPU_OVI_ISSUE_CHECK_EN is defined.
module vpu_ovi_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int SB_W   = 5,
    parameter int OPND_W = 64,
    parameter int VCSR_W = 41
) (
    input logic                  clk,
    input logic                  reset_n,
    vpu_ovi_issue_queue_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_SENIOR = 2'd2,
        ST_KILLED = 2'd3
    } entry_state_e;

    entry_state_e      state_q [DEPTH];
    logic [31:0]       inst_q  [DEPTH];
    logic [SB_W-1:0]   sb_q    [DEPTH];
    logic [OPND_W-1:0] opnd_q  [DEPTH];
    logic [VCSR_W-1:0] vcsr_q  [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rs_ptr;
    logic [AW-1:0]     hd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic              credit_q;

    logic              full;
    logic              head_senior;
    logic              pop;
    logic              issue_ok;
    logic              dispatch_any;
    logic              dispatch_ok;

    assign full         = (occ_q == OCC_W'(DEPTH));
    assign head_senior  = (state_q[hd_ptr] == ST_SENIOR);
    assign pop          = (state_q[hd_ptr] == ST_KILLED) || (head_senior && bus.be_ready);
    // A full queue still takes an issue when the head frees in the same cycle.
    assign issue_ok     = bus.issue_valid && (!full || pop);
    assign dispatch_any = bus.dispatch_next_senior || bus.dispatch_kill;
    // Only a PEND entry registered before this edge can be resolved.
    assign dispatch_ok  = dispatch_any && (state_q[rs_ptr] == ST_PEND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
            end
            wr_ptr   <= '0;
            rs_ptr   <= '0;
            hd_ptr   <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
        end else begin
            // Pop, dispatch and issue touch distinct entries except when a full
            // queue recycles the head slot; the issue write comes last and wins.
            if (pop) begin
                state_q[hd_ptr] <= ST_FREE;
                hd_ptr          <= hd_ptr + AW'(1);
            end
            if (dispatch_ok) begin
                state_q[rs_ptr] <= bus.dispatch_kill ? ST_KILLED : ST_SENIOR;
                rs_ptr          <= rs_ptr + AW'(1);
            end
            if (issue_ok) begin
                state_q[wr_ptr] <= ST_PEND;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            case ({issue_ok, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            credit_q <= pop;
        end
    end

    // Payload storage needs no reset: it is only visible behind a SENIOR state.
    always_ff @(posedge clk) begin
        if (issue_ok) begin
            inst_q[wr_ptr] <= bus.issue_inst;
            sb_q[wr_ptr]   <= bus.issue_sb_id;
            opnd_q[wr_ptr] <= bus.issue_scalar_opnd;
            vcsr_q[wr_ptr] <= bus.issue_vcsr;
        end
    end

    assign bus.be_valid       = head_senior;
    assign bus.be_inst        = head_senior ? inst_q[hd_ptr] : '0;
    assign bus.be_sb_id       = head_senior ? sb_q[hd_ptr]   : '0;
    assign bus.be_scalar_opnd = head_senior ? opnd_q[hd_ptr] : '0;
    assign bus.be_vcsr        = head_senior ? vcsr_q[hd_ptr] : '0;
    assign bus.issue_credit   = credit_q;
    assign bus.occupancy      = occ_q;

`ifdef VPU_OVI_ISSUE_CHECK_EN
    logic err_q;
    logic id_mismatch;
    logic err_event;

    // A mismatched id is flagged but the dispatch still resolves the entry at rs.
    assign id_mismatch = dispatch_ok && (bus.dispatch_sb_id != sb_q[rs_ptr]);
    assign err_event   = (bus.issue_valid && !issue_ok)
                       || (dispatch_any && !dispatch_ok)
                       || (bus.dispatch_next_senior && bus.dispatch_kill)
                       || id_mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign bus.proto_err = err_q;
`else
    logic unused_dispatch_id;
    assign unused_dispatch_id = ^bus.dispatch_sb_id;
    assign bus.proto_err      = 1'b0;
`endif

    occ_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        occ_q <= OCC_W'(DEPTH));
    be_held: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.be_valid && !bus.be_ready) |=> (bus.be_valid && $stable(bus.be_sb_id)
                                             && $stable(bus.be_inst)));
endmodule

// File: doc/vpu_ovi_issue_queue.md
# vpu_ovi_issue_queue

Parametrised OVI issue-side buffer between the scalar core's vector issue/dispatch interface and the vector backend. It holds speculatively issued vector instructions in a DEPTH-entry circular queue and resolves each one in order as senior or killed via the dispatch port. Senior instructions are released to the backend over a valid/ready handshake, and one issue credit is returned to the core per freed entry. It generalises the fixed single-slot OVI front end to a configurable queue depth and payload width, with in-order kill handling.

## Interface
- DEPTH, 4: queue entries and initial core credit count; power of 2, ≥2
- SB_W, 5: scoreboard id width
- OPND_W, 64: scalar operand width
- VCSR_W, 41: vcsr payload width (40-bit vcsr plus lmulb2 bit, concatenated as {lmulb2, vcsr})
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- issue_inst  in  32  instruction word
- issue_sb_id  in  SB_W  scoreboard id
- issue_scalar_opnd  in  OPND_W  scalar operand
- issue_vcsr  in  VCSR_W  vcsr payload
- issue_valid  in  1  issue strobe; no ready, governed by credits
- issue_credit  out  1  one-cycle pulse per freed entry
- dispatch_sb_id  in  SB_W  id being resolved
- dispatch_next_senior  in  1  oldest unresolved entry becomes senior
- dispatch_kill  in  1  oldest unresolved entry is killed
- be_valid  out  1  head entry is senior and presented
- be_ready  in  1  backend accepts head
- be_inst  out  32  head instruction
- be_sb_id  out  SB_W  head id
- be_scalar_opnd  out  OPND_W  head operand
- be_vcsr  out  VCSR_W  head vcsr
- occupancy  out  $clog2(DEPTH+1)  allocated entries, killed but unpopped included
- proto_err  out  1  sticky protocol-error flag

## Operation
- Three pointers: wr (allocate), rs (oldest unresolved), hd (head). Per-entry state: FREE, PEND, SENIOR, KILLED.
- Issue: issue_valid writes the payload at wr, sets PEND, and advances wr. If the queue is full, the payload is dropped and counts as an error.
- Dispatch: next_senior or kill acts on the entry at rs only. The entry becomes SENIOR or KILLED and rs advances.
  - Dispatch with no stored PEND entry is ignored and counts as an error.
  - next_senior and kill asserted together act as kill and count as an error.
- Dispatch cannot resolve an entry written in the same cycle.
- Head:
  - hd SENIOR: be_valid=1 with head payload. be_valid&&be_ready pops the entry.
  - hd KILLED: entry pops automatically. be_valid stays 0.
  - hd PEND or FREE: be_valid=0.
- At most one pop per cycle.
- Each pop produces issue_credit=1 in the following cycle.
- occupancy is incremented by an issue and decremented by a pop; both in one cycle leave it unchanged. Pointers wrap modulo DEPTH.
- Reset: all entries FREE; pointers 0; occupancy 0; issue_credit 0; be_valid 0; be_* payload 0; proto_err 0. Reset mid-operation discards all entries and does not return credits; the core re-initialises to DEPTH credits.

## Timing
- Issue at edge N: entry stored at N. occupancy reflects it from N+1. Earliest dispatch is at edge N+1.
- Senior at edge M with entry at head: be_valid=1 from M+1, combinational from state registers.
- Pop at edge P: issue_credit high during cycle P+1 only. Back-to-back pops give a continuous credit pulse train.
- A killed head pops one cycle after it is marked KILLED at the head position.
- be_* outputs are stable while be_valid=1 and be_ready=0.
- Full queue with pop and issue in the same cycle: the issue is accepted, because the slot frees at that edge.

## Configuration
- VPU_OVI_ISSUE_CHECK_EN defined:
  - proto_err sets on overflow issue, dispatch with nothing pending, or simultaneous senior+kill.
  - proto_err also sets on dispatch_sb_id mismatching the sb_id stored at rs.
  - Once set, proto_err stays set until reset.
  - A mismatched dispatch is still applied to the entry at rs.
- Not defined: proto_err tied 0 and the id comparator is removed. Functional behaviour is otherwise identical.

## Test plan
- DEPTH=4: issue ids 1,2,3; senior 1,2,3; be_ready=1 → be_sb_id sequence 1,2,3; three issue_credit pulses; occupancy returns to 0.
- Issue 1,2; kill 1; senior 2 → no be_valid for id 1; credit pulse, then be_valid with id 2 one cycle later; two credits total.
- Fill all 4 entries, then issue a 5th id 9 → id 9 dropped; occupancy stays 4; proto_err=1 only with VPU_OVI_ISSUE_CHECK_EN defined.
- Head senior with be_ready=0 for 5 cycles → be_* held constant; be_ready=1 pops; credit in the next cycle.
- Issue 4, pop 4 repeatedly across 3 wraps → ids are delivered in order and occupancy never exceeds 4.
- Mid-stream reset_n=0 with 3 entries queued → be_valid=0, occupancy=0, issue_credit=0 immediately, with no credit pulses after release.
